scr_writer: RTL
===============

# scr_writer

Pixel-stream writer for the 160x120, 3-bit screen memories. It accepts single-pixel writes over a valid/ready handshake and converts each (x, y) to a linear address. It also provides a whole-screen fill mode for clearing or initialising a screen. It drives the data/wren port of the screen RAM, which the screen-memory reader scans out, so the team can build screens at runtime instead of only from preloaded images.

## Interface
- WIDTH, 160, screen width in pixels
- HEIGHT, 120, screen height in pixels
- ADDR_W, 15, memory address width
- COLOUR_W, 3, colour width
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- pix_valid  in  1  pixel write request
- pix_ready  out  1  writer can accept a pixel this cycle
- pix_x  in  10  pixel column
- pix_y  in  10  pixel row
- pix_colour  in  COLOUR_W  pixel colour
- fill_go  in  1  start a whole-screen fill; level-sampled in IDLE
- fill_colour  in  COLOUR_W  fill colour, latched when fill_go is accepted
- busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse on the final fill write
- drop_count  out  8  saturating count of out-of-bounds pixels
- mem_address  out  ADDR_W  RAM address
- mem_data  out  COLOUR_W  RAM write data
- mem_wren  out  1  RAM write enable

## Operation
- States: IDLE and FILL. Reset forces IDLE.
- On reset, every output and internal register is 0: busy, fill_done, drop_count, mem_address, mem_data, mem_wren and the fill counter. pix_ready is 0 while reset is asserted and 1 in IDLE after reset.
- pix_ready = (state == IDLE) && !fill_go.
- A pixel transfer occurs when pix_valid && pix_ready.
- In-bounds transfer (pix_x < WIDTH and pix_y < HEIGHT):
  - the next cycle has mem_wren=1, mem_address = pix_y*WIDTH + pix_x, mem_data = pix_colour.
  - The address is computed at ADDR_W width as (y<<7)+(y<<5)+x. The maximum value is 19199, so no overflow occurs.
- Out-of-bounds transfer: the pixel is still accepted (handshake completes), no write occurs, and drop_count increments, holding at 255.
- fill_go in IDLE: takes priority over a simultaneous pix_valid, because pix_ready is low, so that pixel is held off rather than lost.
  - The fill latches fill_colour and enters FILL.
  - FILL writes addresses 0 to WIDTH*HEIGHT-1, one per cycle. mem_data is the latched colour.
  - After the last address the block returns to IDLE.
- fill_go while in FILL is ignored. A fill cannot be restarted or extended.
- mem_wren is 0 in every cycle with no write. mem_address and mem_data hold their last values.
- Reset during a fill aborts it immediately. Memory is left partially filled and no fill_done is generated.

## Timing
- Pixel write latency is 1 cycle: transfer at rising edge N gives mem_wren=1 during cycle N+1. Back-to-back transfers sustain one write per cycle.
- Fill accepted at edge N:
  - busy=1 and the write to address 0 occur in cycle N+1.
  - The write to address 19199 occurs in cycle N+19200, with fill_done=1 in that same cycle.
  - busy=0 and pix_ready=1 in cycle N+19201.
- All outputs except pix_ready are registered.

## Structure
- Shared screen package holds SCR_W=160, SCR_H=120, SCR_PIXELS=19200, SCR_ADDR_W=15, COLOUR_W=3, and the state encoding IDLE=0, FILL=1. The screen-memory reader uses the same constants.
- One sub-module, pix_addr: combinational (x, y) to address plus an in-bounds flag. The same address mapping is reusable by the reader side.

## Test plan
- Reset mid-stream: assert reset asynchronously between edges -> all outputs are 0 immediately. After release pix_ready=1 and drop_count=0.
- Single pixel: x=5, y=2, colour=3'b101 -> next cycle mem_wren=1, mem_address=325, mem_data=5.
- Corners and burst: (0,0), (159,119), (159,0) on consecutive cycles -> addresses 0, 19199, 159 on three consecutive wren cycles.
- Out of bounds: x=160,y=0 then x=0,y=120 then 300 more out-of-bounds pixels -> no wren at any point; drop_count reads 1, then 2, then saturates at 255.
- Fill with collision: fill_go and pix_valid in the same cycle, fill_colour=3'b010 -> pix_ready=0 and the pixel stalls; 19200 writes of 2 over addresses 0..19199; fill_done asserts on the last write; the stalled pixel is written in the cycle after busy drops.
- Fill abort: assert reset at fill write 1000 -> writes stop and no fill_done. A later fill_go runs a full 19200-write fill.

Source files
------------

// File: rtl/scr_writer_pkg.sv
// Shared screen constants and state encoding for the 160x120, 3-bit screen memories.
package scr_writer_pkg;

  localparam int SCR_W      = 160;
  localparam int SCR_H      = 120;
  localparam int SCR_PIXELS = SCR_W * SCR_H;
  localparam int SCR_ADDR_W = 15;
  localparam int COLOUR_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } scr_state_e;

endpackage

// File: rtl/scr_writer_pix_addr.sv
// Combinational (x, y) to linear screen address, plus an in-bounds flag.
// The mapping is y*160 + x, built from shifts because 160 = 128 + 32.
module pix_addr
  import scr_writer_pkg::*;
#(
  parameter int WIDTH  = SCR_W,
  parameter int HEIGHT = SCR_H,
  parameter int ADDR_W = SCR_ADDR_W
) (
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_bounds
);

  // Address is only meaningful when in_bounds is set; the largest valid value is 19199.
  always_comb begin
    addr      = (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
    in_bounds = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
  end

endmodule

// File: rtl/scr_writer.sv
// Pixel-stream writer: single-pixel writes over valid/ready plus a whole-screen fill mode,
// driving the data/wren port of a screen RAM.
module scr_writer
  import scr_writer_pkg::*;
#(
  parameter int WIDTH    = scr_writer_pkg::SCR_W,
  parameter int HEIGHT   = scr_writer_pkg::SCR_H,
  parameter int ADDR_W   = scr_writer_pkg::SCR_ADDR_W,
  parameter int COLOUR_W = scr_writer_pkg::COLOUR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic [9:0]          pix_x,
  input  logic [9:0]          pix_y,
  input  logic [COLOUR_W-1:0] pix_colour,
  input  logic                fill_go,
  input  logic [COLOUR_W-1:0] fill_colour,
  output logic                busy,
  output logic                fill_done,
  output logic [7:0]          drop_count,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_wren
);

  localparam logic [ADDR_W-1:0] PIXELS    = ADDR_W'(WIDTH * HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  scr_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [COLOUR_W-1:0] fill_colour_q, fill_colour_d;
  logic                busy_q, busy_d;
  logic                fill_done_q, fill_done_d;
  logic [7:0]          drop_count_q, drop_count_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [COLOUR_W-1:0] mem_data_q, mem_data_d;
  logic                mem_wren_q, mem_wren_d;

  logic [ADDR_W-1:0]   pix_lin_addr;
  logic                pix_in_bounds;
  logic                pix_xfer;

  pix_addr #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_pix_addr (
    .x         (pix_x),
    .y         (pix_y),
    .addr      (pix_lin_addr),
    .in_bounds (pix_in_bounds)
  );

  // A pending fill request holds pixels off so they stall rather than get lost.
  assign pix_ready = (state_q == IDLE) && !fill_go && !reset;
  assign pix_xfer  = pix_valid && pix_ready;

  // Next-state and registered-output logic; the fill counter holds the next address to write.
  always_comb begin
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    fill_colour_d = fill_colour_q;
    busy_d        = 1'b0;
    fill_done_d   = 1'b0;
    drop_count_d  = drop_count_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_wren_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fill_go) begin
          state_d       = FILL;
          fill_colour_d = fill_colour;
          busy_d        = 1'b1;
          mem_wren_d    = 1'b1;
          mem_address_d = '0;
          mem_data_d    = fill_colour;
          fill_cnt_d    = ADDR_W'(1);
        end else if (pix_xfer) begin
          if (pix_in_bounds) begin
            mem_wren_d    = 1'b1;
            mem_address_d = pix_lin_addr;
            mem_data_d    = pix_colour;
          end else if (drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
          end
        end
      end
      FILL: begin
        if (fill_cnt_q != PIXELS) begin
          busy_d        = 1'b1;
          mem_wren_d    = 1'b1;
          mem_address_d = fill_cnt_q;
          mem_data_d    = fill_colour_q;
          fill_cnt_d    = fill_cnt_q + ADDR_W'(1);
          fill_done_d   = (fill_cnt_q == LAST_ADDR);
        end else begin
          state_d    = IDLE;
          fill_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        fill_cnt_d = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any fill in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      fill_cnt_q    <= '0;
      fill_colour_q <= '0;
      busy_q        <= 1'b0;
      fill_done_q   <= 1'b0;
      drop_count_q  <= '0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      fill_colour_q <= fill_colour_d;
      busy_q        <= busy_d;
      fill_done_q   <= fill_done_d;
      drop_count_q  <= drop_count_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
    end
  end

  assign busy        = busy_q;
  assign fill_done   = fill_done_q;
  assign drop_count  = drop_count_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_wren    = mem_wren_q;

endmodule
